// File: rtl/ping_scheduler.sv
// ping_scheduler
// Runs one sonar ping at a time through BURST, BLANK, LISTEN and REPORT.
// Generates the transmit gate, the ADC sample triggers and the receive-chain clear.
// Time-stamps the first echo heard in LISTEN.
// Hands {beam angle, echo time} to the consumer over a valid/ready handshake.
// The beam angle sweeps back and forth between the limits, one step per accepted result.
// Every output is a flop that is loaded from the next-state decode, so each output
// lines up with the state it belongs to, and a reset clears it at once.

module ping_scheduler #(
  parameter int BURST_CYCLES  = 524288,
  parameter int BLANK_CYCLES  = 65536,
  parameter int LISTEN_CYCLES = 8388608,
  parameter int SAMPLE_PERIOD = 100,
  parameter int ANGLE_WIDTH   = 8,
  parameter int ANGLE_MIN     = -30,
  parameter int ANGLE_MAX     = 30,
  parameter int ANGLE_STEP    = 10,
  parameter int CNT_WIDTH     = 24
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   enable_in,
  input  logic                   echo_in,
  input  logic                   result_ready_in,
  output logic                   burst_start_out,
  output logic                   burst_active_out,
  output logic                   listen_active_out,
  output logic                   sample_trigger_out,
  output logic [ANGLE_WIDTH-1:0] beam_angle_out,
  output logic                   result_valid_out,
  output logic                   echo_found_out,
  output logic [CNT_WIDTH-1:0]   echo_time_out
);

  // The phase counter only has to reach the longest timed phase minus one.
  localparam int PH_MAX_BB = (BURST_CYCLES > BLANK_CYCLES) ? BURST_CYCLES : BLANK_CYCLES;
  localparam int PH_MAX    = (PH_MAX_BB > LISTEN_CYCLES) ? PH_MAX_BB : LISTEN_CYCLES;
  localparam int PH_W      = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int SP_W      = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  localparam logic [PH_W-1:0] BURST_LAST  = PH_W'(BURST_CYCLES - 1);
  localparam logic [PH_W-1:0] BLANK_LAST  = PH_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [PH_W-1:0] LISTEN_LAST = PH_W'(LISTEN_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_ONE      = PH_W'(1);
  localparam logic [SP_W-1:0] SAMPLE_LAST = SP_W'(SAMPLE_PERIOD - 1);
  localparam logic [SP_W-1:0] SP_ONE      = SP_W'(1);

  localparam logic [CNT_WIDTH-1:0] ELAPSED_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  localparam logic signed [ANGLE_WIDTH-1:0] A_MIN  = ANGLE_WIDTH'(ANGLE_MIN);
  localparam logic signed [ANGLE_WIDTH-1:0] A_MAX  = ANGLE_WIDTH'(ANGLE_MAX);
  localparam logic signed [ANGLE_WIDTH-1:0] A_STEP = ANGLE_WIDTH'(ANGLE_STEP);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BURST  = 3'd1,
    BLANK  = 3'd2,
    LISTEN = 3'd3,
    REPORT = 3'd4
  } state_t;

  state_t                          state;
  state_t                          state_next;
  logic [PH_W-1:0]                 phase;
  logic [PH_W-1:0]                 phase_next;
  logic [SP_W-1:0]                 samp;
  logic [SP_W-1:0]                 samp_next;
  logic [CNT_WIDTH-1:0]            elapsed;
  logic [CNT_WIDTH-1:0]            elapsed_next;
  logic signed [ANGLE_WIDTH-1:0]   angle;
  logic signed [ANGLE_WIDTH-1:0]   angle_next;
  logic                            dir_up;
  logic                            dir_next;
  logic                            handshake;
  logic                            start_d;
  logic                            burst_d;
  logic                            listen_d;
  logic                            trig_d;
  logic                            valid_d;

  // State register; a reset aborts any ping in flight and returns to IDLE.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: timed phases end on their last phase count, REPORT waits for the handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable_in) state_next = BURST;
      end
      BURST: begin
        if (phase == BURST_LAST) state_next = (BLANK_CYCLES == 0) ? LISTEN : BLANK;
      end
      BLANK: begin
        if (phase == BLANK_LAST) state_next = LISTEN;
      end
      LISTEN: begin
        if (phase == LISTEN_LAST) state_next = REPORT;
      end
      REPORT: begin
        if (result_ready_in) state_next = enable_in ? BURST : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters and sweep update: the phase count restarts on every state change and the elapsed time restarts on each new burst.
  always_comb begin
    handshake  = (state == REPORT) && result_ready_in;
    phase_next = (state_next != state) ? '0 : phase + PH_ONE;

    if ((state_next == LISTEN) && (state != LISTEN)) begin
      samp_next = '0;
    end else if (samp == SAMPLE_LAST) begin
      samp_next = '0;
    end else begin
      samp_next = samp + SP_ONE;
    end

    if ((state_next == BURST) && (state != BURST)) begin
      elapsed_next = '0;
    end else if (elapsed == ELAPSED_MAX) begin
      elapsed_next = elapsed;
    end else begin
      elapsed_next = elapsed + CNT_ONE;
    end

    angle_next = angle;
    dir_next   = dir_up;
    if (handshake) begin
      if (dir_up) begin
        if (angle >= A_MAX) begin
          angle_next = A_MAX - A_STEP;
          dir_next   = 1'b0;
        end else begin
          angle_next = angle + A_STEP;
        end
      end else begin
        if (angle <= A_MIN) begin
          angle_next = A_MIN + A_STEP;
          dir_next   = 1'b1;
        end else begin
          angle_next = angle - A_STEP;
        end
      end
    end
  end

  // Output decode from the upcoming state, so each registered output matches the state it describes.
  always_comb begin
    start_d  = (state_next == BURST) && (state != BURST);
    burst_d  = (state_next == BURST);
    listen_d = (state_next == LISTEN);
    trig_d   = (state_next == LISTEN) && (samp_next == '0);
    valid_d  = (state_next == REPORT);
  end

  // Counter and sweep registers; the sweep restarts at angle 0, heading upward.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      phase   <= '0;
      samp    <= '0;
      elapsed <= '0;
      angle   <= '0;
      dir_up  <= 1'b1;
    end else begin
      phase   <= phase_next;
      samp    <= samp_next;
      elapsed <= elapsed_next;
      angle   <= angle_next;
      dir_up  <= dir_next;
    end
  end

  // Registered control outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      burst_start_out    <= 1'b0;
      burst_active_out   <= 1'b0;
      listen_active_out  <= 1'b0;
      sample_trigger_out <= 1'b0;
      result_valid_out   <= 1'b0;
    end else begin
      burst_start_out    <= start_d;
      burst_active_out   <= burst_d;
      listen_active_out  <= listen_d;
      sample_trigger_out <= trig_d;
      result_valid_out   <= valid_d;
    end
  end

  // First-echo capture: only LISTEN echoes count, only the first is kept, and a new burst clears it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      echo_found_out <= 1'b0;
      echo_time_out  <= '0;
    end else if (start_d) begin
      echo_found_out <= 1'b0;
      echo_time_out  <= '0;
    end else if ((state == LISTEN) && echo_in && !echo_found_out) begin
      echo_found_out <= 1'b1;
      echo_time_out  <= elapsed;
    end
  end

  assign beam_angle_out = angle;

endmodule

// File: tb/tb_ping_scheduler.sv
// tb_ping_scheduler
// Directed checks of ping_scheduler with short phases: BURST=4, BLANK=3, LISTEN=10, SAMPLE_PERIOD=3.
// Within a ping, cycle c counts from the first BURST cycle (c=0).
// BURST is c=0..3, BLANK is c=4..6, LISTEN is c=7..16 and REPORT starts at c=17.
// The elapsed time in cycle c is c.

module tb_ping_scheduler;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       enable_in;
  logic       echo_in;
  logic       result_ready_in;
  logic       burst_start_out;
  logic       burst_active_out;
  logic       listen_active_out;
  logic       sample_trigger_out;
  logic [7:0] beam_angle_out;
  logic       result_valid_out;
  logic       echo_found_out;
  logic [23:0] echo_time_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  ping_scheduler #(
    .BURST_CYCLES (4),
    .BLANK_CYCLES (3),
    .LISTEN_CYCLES(10),
    .SAMPLE_PERIOD(3),
    .ANGLE_WIDTH  (8),
    .ANGLE_MIN    (-30),
    .ANGLE_MAX    (30),
    .ANGLE_STEP   (10),
    .CNT_WIDTH    (24)
  ) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .enable_in         (enable_in),
    .echo_in           (echo_in),
    .result_ready_in   (result_ready_in),
    .burst_start_out   (burst_start_out),
    .burst_active_out  (burst_active_out),
    .listen_active_out (listen_active_out),
    .sample_trigger_out(sample_trigger_out),
    .beam_angle_out    (beam_angle_out),
    .result_valid_out  (result_valid_out),
    .echo_found_out    (echo_found_out),
    .echo_time_out     (echo_time_out)
  );

  // Advance one cycle and settle just after the rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Walk a ping from c=0 to c=16, driving echo_in from echo_at[c].
  // Returns with the bench sitting at c=17.
  task automatic run_ping(input logic [16:0] echo_at, output int n_start, output int n_burst,
                          output int n_listen, output int n_trig, output logic [9:0] trig_pos,
                          output int n_valid, output logic [7:0] angle0, output int moves);
    n_start = 0; n_burst = 0; n_listen = 0; n_trig = 0; n_valid = 0; moves = 0;
    trig_pos = '0;
    angle0 = beam_angle_out;
    for (int c = 0; c < 17; c++) begin
      echo_in = echo_at[c];
      if (burst_start_out) n_start++;
      if (burst_active_out) n_burst++;
      if (listen_active_out) n_listen++;
      if (result_valid_out) n_valid++;
      if (sample_trigger_out) begin
        n_trig++;
        if (c >= 7) trig_pos = trig_pos | (10'd1 << (c - 7));
      end
      if (beam_angle_out !== angle0) moves++;
      step();
    end
    echo_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; enable_in = 1'b0; echo_in = 1'b0; result_ready_in = 1'b1;
    #1;
    n_checks++;
    if ({burst_start_out, burst_active_out, listen_active_out, sample_trigger_out,
         result_valid_out, echo_found_out} !== 6'b0) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b, expected 000000", {burst_start_out,
        burst_active_out, listen_active_out, sample_trigger_out, result_valid_out, echo_found_out});
    end
    n_checks++;
    if (beam_angle_out !== 8'd0 || echo_time_out !== 24'd0) begin
      n_fail++; $display("[TB] FAIL reset_fields: angle %0d time %0d, expected 0 and 0",
        $signed(beam_angle_out), echo_time_out);
    end
    step(); step();
    rst_n_in = 1'b1;
    step(); step();
    n_checks++;
    if (burst_active_out !== 1'b0 || result_valid_out !== 1'b0) begin
      n_fail++; $display("[TB] FAIL idle_no_enable: burst %b valid %b, expected 0 0",
        burst_active_out, result_valid_out);
    end
  endtask

  task automatic test_basic_ping();
    int n_start, n_burst, n_listen, n_trig, n_valid, moves, wait_cyc;
    logic [9:0] trig_pos;
    logic [7:0] angle0;
    logic got;
    enable_in = 1'b1;
    got = 1'b0;
    wait_cyc = 0;
    while (!got && wait_cyc < 10) begin
      step(); wait_cyc++;
      if (burst_start_out) got = 1'b1;
    end
    n_checks++;
    if (!got || wait_cyc != 1) begin
      n_fail++; $display("[TB] FAIL first_start_latency: got %0d cycles (seen %b), expected 1", wait_cyc, got);
    end
    run_ping(17'h0, n_start, n_burst, n_listen, n_trig, trig_pos, n_valid, angle0, moves);
    n_checks++;
    if (n_start != 1) begin n_fail++; $display("[TB] FAIL basic_start_count: got %0d, expected 1", n_start); end
    n_checks++;
    if (n_burst != 4) begin n_fail++; $display("[TB] FAIL basic_burst_len: got %0d, expected 4", n_burst); end
    n_checks++;
    if (n_listen != 10) begin n_fail++; $display("[TB] FAIL basic_listen_len: got %0d, expected 10", n_listen); end
    n_checks++;
    if (n_trig != 4 || trig_pos !== 10'b1001001001) begin
      n_fail++; $display("[TB] FAIL basic_triggers: got %0d at %b, expected 4 at 1001001001", n_trig, trig_pos);
    end
    n_checks++;
    if (n_valid != 0 || result_valid_out !== 1'b1) begin
      n_fail++; $display("[TB] FAIL basic_valid_timing: early %0d, at c17 %b, expected 0 and 1", n_valid, result_valid_out);
    end
    n_checks++;
    if (echo_found_out !== 1'b0 || echo_time_out !== 24'd0 || angle0 !== 8'd0 || moves != 0) begin
      n_fail++; $display("[TB] FAIL basic_result: found %b time %0d angle %0d moves %0d, expected 0 0 0 0",
        echo_found_out, echo_time_out, $signed(angle0), moves);
    end
    step();
    // Counting the first burst_start cycle as cycle 1, the next one falls in cycle 19.
    n_checks++;
    if (burst_start_out !== 1'b1 || result_valid_out !== 1'b0) begin
      n_fail++; $display("[TB] FAIL basic_next_start: start %b valid %b, expected 1 0", burst_start_out, result_valid_out);
    end
  endtask

  task automatic test_echo_capture();
    int n_start, n_burst, n_listen, n_trig, n_valid, moves;
    logic [9:0] trig_pos;
    logic [7:0] angle0;
    // Echoes at c=5 (BLANK), c=9 (LISTEN 2) and c=12 (LISTEN 5).
    run_ping(17'h01220, n_start, n_burst, n_listen, n_trig, trig_pos, n_valid, angle0, moves);
    n_checks++;
    if (echo_found_out !== 1'b1 || echo_time_out !== 24'd9) begin
      n_fail++; $display("[TB] FAIL echo_first: found %b time %0d, expected 1 9", echo_found_out, echo_time_out);
    end
    n_checks++;
    if (angle0 !== 8'd10) begin n_fail++; $display("[TB] FAIL echo_angle: got %0d, expected 10", $signed(angle0)); end
    step();
    n_checks++;
    if (burst_start_out !== 1'b1 || echo_found_out !== 1'b0 || echo_time_out !== 24'd0) begin
      n_fail++; $display("[TB] FAIL echo_clear_on_start: start %b found %b time %0d, expected 1 0 0",
        burst_start_out, echo_found_out, echo_time_out);
    end
  endtask

  task automatic test_no_echo_and_last_cycle();
    int n_start, n_burst, n_listen, n_trig, n_valid, moves;
    logic [9:0] trig_pos;
    logic [7:0] angle0;
    run_ping(17'h0, n_start, n_burst, n_listen, n_trig, trig_pos, n_valid, angle0, moves);
    n_checks++;
    if (echo_found_out !== 1'b0 || echo_time_out !== 24'd0 || angle0 !== 8'd20) begin
      n_fail++; $display("[TB] FAIL no_echo: found %b time %0d angle %0d, expected 0 0 20",
        echo_found_out, echo_time_out, $signed(angle0));
    end
    step();
    // Echoes at c=3 (BURST, ignored) and c=16 (last LISTEN cycle).
    run_ping(17'h10008, n_start, n_burst, n_listen, n_trig, trig_pos, n_valid, angle0, moves);
    n_checks++;
    if (echo_found_out !== 1'b1 || echo_time_out !== 24'd16 || angle0 !== 8'd30) begin
      n_fail++; $display("[TB] FAIL last_cycle_echo: found %b time %0d angle %0d, expected 1 16 30",
        echo_found_out, echo_time_out, $signed(angle0));
    end
    step();
  endtask

  task automatic test_ready_hold();
    int n_start, n_burst, n_listen, n_trig, n_valid, moves, held;
    logic [9:0] trig_pos;
    logic [7:0] angle0;
    result_ready_in = 1'b0;
    run_ping(17'h00400, n_start, n_burst, n_listen, n_trig, trig_pos, n_valid, angle0, moves);
    held = 0;
    for (int h = 0; h < 5; h++) begin
      echo_in = 1'b1;
      if (result_valid_out === 1'b1 && burst_start_out === 1'b0 && echo_found_out === 1'b1 &&
          echo_time_out === 24'd10 && beam_angle_out === 8'd20) held++;
      step();
    end
    echo_in = 1'b0;
    n_checks++;
    if (held != 5) begin n_fail++; $display("[TB] FAIL ready_hold_cycles: got %0d good cycles, expected 5", held); end
    n_checks++;
    if (result_valid_out !== 1'b1 || echo_time_out !== 24'd10 || beam_angle_out !== 8'd20) begin
      n_fail++; $display("[TB] FAIL ready_hold_end: valid %b time %0d angle %0d, expected 1 10 20",
        result_valid_out, echo_time_out, $signed(beam_angle_out));
    end
    result_ready_in = 1'b1;
    step();
    n_checks++;
    if (burst_start_out !== 1'b1 || result_valid_out !== 1'b0 || beam_angle_out !== 8'd10) begin
      n_fail++; $display("[TB] FAIL ready_release: start %b valid %b angle %0d, expected 1 0 10",
        burst_start_out, result_valid_out, $signed(beam_angle_out));
    end
  endtask

  task automatic test_sweep();
    int n_start, n_burst, n_listen, n_trig, n_valid, moves;
    logic [9:0] trig_pos;
    logic [7:0] angle0;
    logic [7:0] exp_angle [6];
    exp_angle[0] = 8'd10;  exp_angle[1] = 8'd0;   exp_angle[2] = 8'hF6;
    exp_angle[3] = 8'hEC;  exp_angle[4] = 8'hE2;  exp_angle[5] = 8'hEC;
    for (int p = 0; p < 6; p++) begin
      run_ping(17'h0, n_start, n_burst, n_listen, n_trig, trig_pos, n_valid, angle0, moves);
      n_checks++;
      if (angle0 !== exp_angle[p] || moves != 0 || beam_angle_out !== exp_angle[p]) begin
        n_fail++; $display("[TB] FAIL sweep_angle_%0d: got %0d (moves %0d), expected %0d", p,
          $signed(angle0), moves, $signed(exp_angle[p]));
      end
      step();
      n_checks++;
      if (burst_start_out !== 1'b1) begin n_fail++; $display("[TB] FAIL sweep_restart_%0d: got %b, expected 1", p, burst_start_out); end
    end
  endtask

  task automatic test_reset_mid_listen();
    for (int c = 0; c < 11; c++) step();
    n_checks++;
    if (listen_active_out !== 1'b1 || beam_angle_out !== 8'hF6) begin
      n_fail++; $display("[TB] FAIL pre_reset_listen: listen %b angle %0d, expected 1 -10",
        listen_active_out, $signed(beam_angle_out));
    end
    rst_n_in = 1'b0;
    #1;
    n_checks++;
    if ({burst_start_out, burst_active_out, listen_active_out, sample_trigger_out,
         result_valid_out, echo_found_out} !== 6'b0 || beam_angle_out !== 8'd0 || echo_time_out !== 24'd0) begin
      n_fail++; $display("[TB] FAIL async_reset_outputs: flags %b angle %0d time %0d, expected 000000 0 0",
        {burst_start_out, burst_active_out, listen_active_out, sample_trigger_out, result_valid_out,
         echo_found_out}, $signed(beam_angle_out), echo_time_out);
    end
    step(); step();
  endtask

  task automatic test_enable_drop();
    int n_start, n_burst, n_listen, n_trig, n_valid, moves, wait_cyc, stray;
    logic [9:0] trig_pos;
    logic [7:0] angle0;
    logic got;
    enable_in = 1'b1;
    rst_n_in = 1'b1;
    got = 1'b0;
    wait_cyc = 0;
    while (!got && wait_cyc < 10) begin
      step(); wait_cyc++;
      if (burst_start_out) got = 1'b1;
    end
    n_checks++;
    if (!got) begin n_fail++; $display("[TB] FAIL drop_start: no burst_start within 10 cycles, expected one"); end
    enable_in = 1'b0;
    run_ping(17'h0, n_start, n_burst, n_listen, n_trig, trig_pos, n_valid, angle0, moves);
    n_checks++;
    if (n_burst != 4 || n_listen != 10 || result_valid_out !== 1'b1 || angle0 !== 8'd0) begin
      n_fail++; $display("[TB] FAIL drop_completes: burst %0d listen %0d valid %b angle %0d, expected 4 10 1 0",
        n_burst, n_listen, result_valid_out, $signed(angle0));
    end
    step();
    n_checks++;
    if (burst_start_out !== 1'b0 || result_valid_out !== 1'b0 || beam_angle_out !== 8'd10) begin
      n_fail++; $display("[TB] FAIL drop_to_idle: start %b valid %b angle %0d, expected 0 0 10",
        burst_start_out, result_valid_out, $signed(beam_angle_out));
    end
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      if (burst_active_out || listen_active_out || result_valid_out || burst_start_out) stray++;
      step();
    end
    n_checks++;
    if (stray != 0) begin n_fail++; $display("[TB] FAIL drop_stays_idle: got %0d active cycles, expected 0", stray); end
  endtask

  // Run the scenarios in order; each one leaves the design where the next one expects it.
  initial begin
    test_reset();
    test_basic_ping();
    test_echo_capture();
    test_no_echo_and_last_cycle();
    test_ready_hold();
    test_sweep();
    test_reset_mid_listen();
    test_enable_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
